// File: rtl/uart_cmd_parser_if.sv
//------------------------------------------------------------------------------
// Module  : uart_cmd_parser_if
// Brief   : Byte stream in, digit set and load/error strobes out, for the
//           UART command parser.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic       ld_time;
    logic       ld_alarm;
    logic [3:0] d_mtens;
    logic [3:0] d_mones;
    logic [3:0] d_stens;
    logic [3:0] d_sones;
    logic       cmd_err;
    logic       busy;

    modport master (
        output rx_data, rx_data_rdy,
        input  ld_time, ld_alarm, d_mtens, d_mones, d_stens, d_sones,
               cmd_err, busy
    );

    modport slave (
        input  rx_data, rx_data_rdy,
        output ld_time, ld_alarm, d_mtens, d_mones, d_stens, d_sones,
               cmd_err, busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_cmd_parser.sv
//------------------------------------------------------------------------------
// Module  : uart_cmd_parser
// Brief   : Decodes "l/L + MMSS + CR" from the UART byte stream into time or
//           alarm loads for the clock core; malformed or stalled commands
//           raise a one-cycle error strobe.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_cmd_parser #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd12_000_000
) (
    input  wire logic         clk12m,
    input  wire logic         rst,
    uart_cmd_parser_if.slave  bus
);

    localparam logic [7:0] c_char_time  = 8'h6C;
    localparam logic [7:0] c_char_alarm = 8'h4C;
    localparam logic [7:0] c_char_cr    = 8'h0D;
    localparam logic [7:0] c_char_zero  = 8'h30;
    localparam logic [7:0] c_char_nine  = 8'h39;
    localparam logic [3:0] c_tens_max   = 4'd5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DIG0 = 3'd1,
        S_DIG1 = 3'd2,
        S_DIG2 = 3'd3,
        S_DIG3 = 3'd4,
        S_WCR  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_mode;
    logic        w_mode_nxt;
    logic [3:0]  r_sh_mtens, r_sh_mones, r_sh_stens, r_sh_sones;
    logic [3:0]  w_sh_mtens_nxt, w_sh_mones_nxt, w_sh_stens_nxt, w_sh_sones_nxt;
    logic [23:0] r_cnt;
    logic [23:0] w_cnt_nxt;
    logic [23:0] w_cnt_inc;
    logic        w_commit;
    logic        w_err;

    logic        r_ld_time;
    logic        r_ld_alarm;
    logic        r_cmd_err;
    logic        r_busy;
    logic [3:0]  r_d_mtens, r_d_mones, r_d_stens, r_d_sones;

    logic        w_is_open;
    logic        w_open_mode;
    logic        w_is_digit;
    logic [3:0]  w_dig;
    logic        w_tens_ok;

    assign w_is_open   = (bus.rx_data == c_char_time) || (bus.rx_data == c_char_alarm);
    assign w_open_mode = (bus.rx_data == c_char_alarm);
    assign w_is_digit  = (bus.rx_data >= c_char_zero) && (bus.rx_data <= c_char_nine);
    // For '0'..'9' the ASCII low nibble already equals the digit value.
    assign w_dig       = bus.rx_data[3:0];
    assign w_tens_ok   = w_is_digit && (w_dig <= c_tens_max);
    assign w_cnt_inc   = (r_cnt == 24'hFF_FFFF) ? r_cnt : (r_cnt + 24'd1);

    always_comb begin
        w_state_nxt    = r_state;
        w_mode_nxt     = r_mode;
        w_sh_mtens_nxt = r_sh_mtens;
        w_sh_mones_nxt = r_sh_mones;
        w_sh_stens_nxt = r_sh_stens;
        w_sh_sones_nxt = r_sh_sones;
        w_cnt_nxt      = r_cnt;
        w_commit       = 1'b0;
        w_err          = 1'b0;

        if (r_state == S_IDLE) begin
            w_cnt_nxt = '0;
            if (bus.rx_data_rdy && w_is_open) begin
                w_mode_nxt  = w_open_mode;
                w_state_nxt = S_DIG0;
            end
        end else if (bus.rx_data_rdy) begin
            w_cnt_nxt = '0;
            if (w_is_open) begin
                // A fresh opener aborts the open command and starts the new one.
                w_err       = 1'b1;
                w_mode_nxt  = w_open_mode;
                w_state_nxt = S_DIG0;
            end else begin
                w_err       = 1'b1;
                w_state_nxt = S_IDLE;
                case (r_state)
                    S_DIG0: if (w_tens_ok) begin
                        w_err = 1'b0; w_sh_mtens_nxt = w_dig; w_state_nxt = S_DIG1;
                    end
                    S_DIG1: if (w_is_digit) begin
                        w_err = 1'b0; w_sh_mones_nxt = w_dig; w_state_nxt = S_DIG2;
                    end
                    S_DIG2: if (w_tens_ok) begin
                        w_err = 1'b0; w_sh_stens_nxt = w_dig; w_state_nxt = S_DIG3;
                    end
                    S_DIG3: if (w_is_digit) begin
                        w_err = 1'b0; w_sh_sones_nxt = w_dig; w_state_nxt = S_WCR;
                    end
                    S_WCR: if (bus.rx_data == c_char_cr) begin
                        w_err = 1'b0; w_commit = 1'b1;
                    end
                    default: w_err = 1'b0;
                endcase
            end
        end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc >= TIMEOUT_CYC) begin
                w_err       = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk12m) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mode     <= 1'b0;
            r_sh_mtens <= '0;
            r_sh_mones <= '0;
            r_sh_stens <= '0;
            r_sh_sones <= '0;
            r_cnt      <= '0;
            r_ld_time  <= 1'b0;
            r_ld_alarm <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_busy     <= 1'b0;
            r_d_mtens  <= '0;
            r_d_mones  <= '0;
            r_d_stens  <= '0;
            r_d_sones  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mode     <= w_mode_nxt;
            r_sh_mtens <= w_sh_mtens_nxt;
            r_sh_mones <= w_sh_mones_nxt;
            r_sh_stens <= w_sh_stens_nxt;
            r_sh_sones <= w_sh_sones_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ld_time  <= w_commit && !r_mode;
            r_ld_alarm <= w_commit &&  r_mode;
            r_cmd_err  <= w_err;
            r_busy     <= (w_state_nxt != S_IDLE);
            if (w_commit) begin
                r_d_mtens <= r_sh_mtens;
                r_d_mones <= r_sh_mones;
                r_d_stens <= r_sh_stens;
                r_d_sones <= r_sh_sones;
            end
        end
    end

    assign bus.ld_time  = r_ld_time;
    assign bus.ld_alarm = r_ld_alarm;
    assign bus.cmd_err  = r_cmd_err;
    assign bus.busy     = r_busy;
    assign bus.d_mtens  = r_d_mtens;
    assign bus.d_mones  = r_d_mones;
    assign bus.d_stens  = r_d_stens;
    assign bus.d_sones  = r_d_sones;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_cmd_parser
// Brief   : Directed self-checking bench for uart_cmd_parser.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_cmd_parser;

    logic clk12m = 1'b0;
    logic rst;

    uart_cmd_parser_if bus_if ();

    uart_cmd_parser #(
        .TIMEOUT_CYC (24'd50)
    ) dut (
        .clk12m (clk12m),
        .rst    (rst),
        .bus    (bus_if)
    );

    always #5 clk12m = ~clk12m;

    int n_chk = 0;
    int n_err = 0;
    int n_time = 0, n_alarm = 0, n_cerr = 0, n_both = 0;
    int b_time, b_alarm, b_cerr;
    int k;

    logic [15:0] w_digits;
    assign w_digits = {bus_if.d_mtens, bus_if.d_mones, bus_if.d_stens, bus_if.d_sones};

    always @(negedge clk12m) begin
        if (bus_if.ld_time)                   n_time++;
        if (bus_if.ld_alarm)                  n_alarm++;
        if (bus_if.cmd_err)                   n_cerr++;
        if (bus_if.ld_time && bus_if.ld_alarm) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with outputs settled.
    task automatic tx(input logic [7:0] b);
        bus_if.rx_data     = b;
        bus_if.rx_data_rdy = 1'b1;
        @(negedge clk12m);
        bus_if.rx_data_rdy = 1'b0;
        bus_if.rx_data     = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk12m);
    endtask

    task automatic mark();
        b_time  = n_time;
        b_alarm = n_alarm;
        b_cerr  = n_cerr;
    endtask

    task automatic check_counts(input string tag, input int t, input int a, input int e);
        check({tag, "_ld_time_cnt"},  n_time  - b_time,  t);
        check({tag, "_ld_alarm_cnt"}, n_alarm - b_alarm, a);
        check({tag, "_cmd_err_cnt"},  n_cerr  - b_cerr,  e);
    endtask

    initial begin
        rst                = 1'b1;
        bus_if.rx_data     = 8'h00;
        bus_if.rx_data_rdy = 1'b0;
        repeat (3) @(negedge clk12m);
        rst = 1'b0;
        @(negedge clk12m);

        check("rst_busy",    bus_if.busy,     0);
        check("rst_ld_time", bus_if.ld_time,  0);
        check("rst_ld_alarm",bus_if.ld_alarm, 0);
        check("rst_cmd_err", bus_if.cmd_err,  0);
        check("rst_digits",  w_digits,        16'h0000);

        // Time load back-to-back, then alarm load after 5 idle cycles
        mark();
        tx("l");
        check("open_busy", bus_if.busy, 1);
        tx("5"); tx("9"); tx("5"); tx("5"); tx(8'h0D);
        check("time_ld_pulse", bus_if.ld_time,  1);
        check("time_no_alarm", bus_if.ld_alarm, 0);
        check("time_digits",   w_digits,        16'h5955);
        check("time_busy_low", bus_if.busy,     0);
        idle(5);
        check("time_ld_once",  bus_if.ld_time,  0);
        tx("L"); tx("0"); tx("3"); tx("2"); tx("4"); tx(8'h0D);
        check("alarm_ld_pulse", bus_if.ld_alarm, 1);
        check("alarm_digits",   w_digits,        16'h0324);
        idle(2);
        check_counts("load", 1, 1, 0);

        // Restore 5955 so the error cases can show the digits are untouched
        tx("l"); tx("5"); tx("9"); tx("5"); tx("5"); tx(8'h0D);
        idle(1);

        mark();
        tx("l"); tx("6");
        check("tens_range_err",    bus_if.cmd_err, 1);
        check("tens_range_busy",   bus_if.busy,    0);
        check("tens_range_digits", w_digits,       16'h5955);
        idle(1);
        check("err_one_cycle", bus_if.cmd_err, 0);

        tx("L"); tx("1"); tx("2"); tx("3");
        check("fmt_no_early_err", bus_if.cmd_err, 0);
        tx("x");
        check("fmt_bad_byte_err", bus_if.cmd_err, 1);
        idle(1);

        tx("l"); tx("1"); tx("2"); tx("3"); tx("4");
        check("fifth_no_early_err", bus_if.cmd_err, 0);
        tx("5");
        check("fifth_digit_err",    bus_if.cmd_err, 1);
        check("fifth_digits_kept",  w_digits,       16'h5955);
        idle(2);
        check_counts("errors", 0, 0, 3);

        // Restart mid-command
        mark();
        tx("l"); tx("1"); tx("2"); tx("L");
        check("restart_err",  bus_if.cmd_err, 1);
        check("restart_busy", bus_if.busy,    1);
        tx("0"); tx("0"); tx("0"); tx("1"); tx(8'h0D);
        check("restart_ld_alarm", bus_if.ld_alarm, 1);
        check("restart_digits",   w_digits,        16'h0001);
        idle(2);
        check_counts("restart", 0, 1, 1);

        // Timeout after 50 silent cycles
        mark();
        tx("l"); tx("1");
        k = 0;
        for (int i = 1; i <= 60; i++) begin
            if (bus_if.cmd_err) begin
                k = i - 1;
                break;
            end
            @(negedge clk12m);
        end
        check("timeout_latency", k, 50);
        check("timeout_busy",    bus_if.busy, 0);
        idle(2);
        tx(8'h0D);
        idle(2);
        check("cr_in_idle_busy", bus_if.busy, 0);
        check_counts("timeout", 0, 0, 1);

        // Reset mid-command, byte presented during reset is dropped
        mark();
        tx("L"); tx("2"); tx("3");
        rst                = 1'b1;
        bus_if.rx_data     = "4";
        bus_if.rx_data_rdy = 1'b1;
        @(negedge clk12m);
        rst                = 1'b0;
        bus_if.rx_data_rdy = 1'b0;
        tx("4"); tx(8'h0D);
        idle(2);
        check_counts("midrst", 0, 0, 0);
        check("midrst_digits", w_digits,    16'h0000);
        check("midrst_busy",   bus_if.busy, 0);
        tx("l"); tx("0"); tx("0"); tx("0"); tx("9"); tx(8'h0D);
        check("post_rst_ld_time", bus_if.ld_time, 1);
        check("post_rst_digits",  w_digits,       16'h0009);
        idle(2);

        // Stray bytes in IDLE
        mark();
        tx("a");
        check("stray_a_busy",  bus_if.busy, 0);
        tx(8'h0D);
        check("stray_cr_busy", bus_if.busy, 0);
        tx("5");
        check("stray_5_busy",  bus_if.busy, 0);
        idle(3);
        check_counts("stray", 0, 0, 0);
        check("stray_digits", w_digits, 16'h0009);

        check("never_both_ld", n_both, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command decoder between the UART receiver and the clock/alarm core. It consumes the received byte stream and recognises two commands: `l` followed by four digits and CR loads the time, and `L` followed by four digits and CR loads the alarm. Each accepted command is presented to the core as a stable MM:SS digit set plus a one-cycle load strobe. Malformed or stalled commands are discarded, and a one-cycle error strobe is raised for each one.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 24'd12_000_000: maximum number of idle cycles allowed between bytes of an open command (1 s at 12 MHz).

Ports:
- `clk12m`, input, 1: system clock, 12 MHz.
- `rst`, input, 1: reset, synchronous, active-high.
- `rx_data`, input, 8: received byte; valid only in cycles where `rx_data_rdy` = 1.
- `rx_data_rdy`, input, 1: one-cycle strobe marking a new byte.
- `ld_time`, output, 1: one-cycle pulse; digit outputs hold a new time.
- `ld_alarm`, output, 1: one-cycle pulse; digit outputs hold a new alarm.
- `d_mtens`, output, 4: minutes tens digit, 0-5.
- `d_mones`, output, 4: minutes ones digit, 0-9.
- `d_stens`, output, 4: seconds tens digit, 0-5.
- `d_sones`, output, 4: seconds ones digit, 0-9.
- `cmd_err`, output, 1: one-cycle pulse; the open command was discarded.
- `busy`, output, 1: high while a command is open (state is not IDLE).

## Operation
- Reset values: all outputs 0; state IDLE; shadow digits 0; mode 0; timeout counter 0.
- States: IDLE, DIG0, DIG1, DIG2, DIG3, WCR.
- A 1-bit mode register records the command type: 0 = time, 1 = alarm.
- Bytes are processed only in cycles with `rx_data_rdy` = 1. All other cycles only advance the timeout counter.
- IDLE transitions:
  - `l` (0x6C): mode 0, go to DIG0.
  - `L` (0x4C): mode 1, go to DIG0.
  - Any other byte, including a stray CR: ignored, no error.
- Digit states DIG0-DIG3 capture into shadow registers Mtens, Mones, Stens, Sones, in that order.
  - Accepted bytes are 0x30-0x39.
  - The value stored is the byte minus 0x30, kept as 4 bits.
- Range rule: in DIG0 and DIG2 (tens digits), values 6-9 are errors.
- WCR: 0x0D commits the command. Any other byte is an error.
- Commit action: copy the shadow registers to `d_*`, pulse `ld_time` (mode 0) or `ld_alarm` (mode 1), return to IDLE.
- Error (bad byte, out-of-range digit, or timeout): pulse `cmd_err`, return to IDLE. Shadow registers are left dirty. `d_*` are unchanged.
- Restart rule: `l` or `L` received in any non-IDLE state aborts the open command.
  - `cmd_err` pulses.
  - The parser re-enters DIG0 with the new mode.
  - The restart byte is not consumed as an error-then-ignore; it opens the new command.
- Timeout counter:
  - Cleared on every accepted byte and whenever the state is IDLE.
  - Increments each non-IDLE cycle that has no `rx_data_rdy`.
  - Reaching `TIMEOUT_CYC` counts as an error.
  - Counter width is 24 bits, saturating; it never wraps.
- `d_*` change only on commit and always hold the last committed value.
- `ld_time` and `ld_alarm` are never high in the same cycle.

## Timing
- All outputs are registered.
- A byte sampled at edge N updates state at edge N. Any resulting `ld_*` or `cmd_err` pulse is high for exactly the one cycle following edge N.
- `d_*` update at the same edge `ld_*` rises, so digits and strobe are valid together. The core may sample both on the first edge after the strobe.
- Back-to-back bytes (`rx_data_rdy` high in consecutive cycles) are fully supported; there is no dead cycle after a commit.
- A new command byte can arrive in the same cycle that `ld_*` is high.
- Timeout fires `TIMEOUT_CYC` cycles after the last accepted byte, measured edge to edge.
- Reset mid-command:
  - State goes to IDLE, with no `cmd_err` and no `ld_*` pulse.
  - `d_*` are cleared to 0.
  - A byte arriving in a reset cycle is dropped.
- `busy` rises the cycle after the opening `l`/`L` and falls the cycle after the commit, error, or timeout.

## Test plan
- Time load: `l`,`5`,`9`,`5`,`5`,CR sent back-to-back, then `L`,`0`,`3`,`2`,`4`,CR sent after 5 idle cycles.
  - Required: a single `ld_time` pulse with `d_*` = 5,9,5,5, then a single `ld_alarm` pulse with `d_*` = 0,3,2,4.
  - Required: `cmd_err` never pulses.
- Range and format errors:
  - `l`,`6`: `cmd_err` one cycle after the `6`; `d_*` keep 5,9,5,5; no `ld_*`.
  - `L`,`1`,`2`,`3`,`x`: `cmd_err` on `x`.
  - `l`,`1`,`2`,`3`,`4`,`5`: `cmd_err` on the 5th digit.
- Restart: `l`,`1`,`2`,`L`,`0`,`0`,`0`,`1`,CR.
  - Required: `cmd_err` pulse on the `L`, then `ld_alarm` with `d_*` = 0,0,0,1.
  - Required: no `ld_time`.
- Timeout, with `TIMEOUT_CYC` = 50:
  - `l`,`1` then silence: `cmd_err` exactly 50 cycles after the `1`; `busy` falls.
  - Later CR alone in IDLE: ignored, no pulses.
- Reset mid-command: `L`,`2`,`3`, assert `rst` for 1 cycle, then `4`,CR.
  - Required: no `ld_*` and no `cmd_err`; `d_*` = 0; `busy` = 0.
  - Then `l`,`0`,`0`,`0`,`9`,CR: `ld_time` with `d_*` = 0,0,0,9.
- Stray bytes in IDLE (`a`, CR, `5`): no outputs change and `busy` stays 0.
